// File: rtl/ifu_fetch_queue.sv
// Fetch queue between static branch prediction and decode.
// Circular buffer of {inst, pc, prediction} tuples with flush on redirect.
module ifu_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_valid_i,
  output logic                       push_ready_o,
  input  logic [DATA_W-1:0]          push_inst_i,
  input  logic [ADDR_W-1:0]          push_pc_i,
  input  logic                       push_pred_taken_i,
  input  logic [ADDR_W-1:0]          push_pred_addr_i,
  input  logic                       push_is_pred_branch_i,
  input  logic                       push_is_pred_jalr_i,
  output logic                       pop_valid_o,
  input  logic                       pop_ready_i,
  output logic [DATA_W-1:0]          pop_inst_o,
  output logic [ADDR_W-1:0]          pop_pc_o,
  output logic                       pop_pred_taken_o,
  output logic [ADDR_W-1:0]          pop_pred_addr_o,
  output logic                       pop_is_pred_branch_o,
  output logic                       pop_is_pred_jalr_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
    logic              taken;
    logic [ADDR_W-1:0] addr;
    logic              is_br;
    logic              is_jalr;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push_fire;
  logic            pop_fire;

  assign push_ready_o = (count != FULL);
  assign pop_valid_o  = (count != '0);
  assign push_fire    = push_valid_i & push_ready_o & ~flush_i;
  assign pop_fire     = pop_valid_o & pop_ready_i & ~flush_i;
  assign count_o      = count;

  assign head                 = mem[rd_ptr];
  assign pop_inst_o           = head.inst;
  assign pop_pc_o             = head.pc;
  assign pop_pred_taken_o     = head.taken;
  assign pop_pred_addr_o      = head.addr;
  assign pop_is_pred_branch_o = head.is_br;
  assign pop_is_pred_jalr_o   = head.is_jalr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) begin
        mem[wr_ptr] <= '{
          inst:    push_inst_i,
          pc:      push_pc_i,
          taken:   push_pred_taken_i,
          addr:    push_pred_addr_i,
          is_br:   push_is_pred_branch_i,
          is_jalr: push_is_pred_jalr_i
        };
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_fire)
        rd_ptr <= rd_ptr + PW'(1);
      unique case (1'b1)
        push_fire & ~pop_fire: count <= count + CW'(1);
        pop_fire & ~push_fire: count <= count - CW'(1);
        default:               count <= count;
      endcase
    end
  end

  // Underflow wraps the unsigned count above DEPTH, so one bound covers both.
  always_ff @(posedge clk) begin
    if (rst_n)
      assert (count <= FULL)
        else $error("fetch queue count out of range: %0d", count);
  end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed testbench for ifu_fetch_queue.
// Inputs change 1ns after posedge; outputs are sampled there too.
module tb_ifu_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        push_valid_i;
  logic        push_ready_o;
  logic [31:0] push_inst_i;
  logic [31:0] push_pc_i;
  logic        push_pred_taken_i;
  logic [31:0] push_pred_addr_i;
  logic        push_is_pred_branch_i;
  logic        push_is_pred_jalr_i;
  logic        pop_valid_o;
  logic        pop_ready_i;
  logic [31:0] pop_inst_o;
  logic [31:0] pop_pc_o;
  logic        pop_pred_taken_o;
  logic [31:0] pop_pred_addr_o;
  logic        pop_is_pred_branch_o;
  logic        pop_is_pred_jalr_o;
  logic [2:0]  count_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ifu_fetch_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .flush_i              (flush_i),
    .push_valid_i         (push_valid_i),
    .push_ready_o         (push_ready_o),
    .push_inst_i          (push_inst_i),
    .push_pc_i            (push_pc_i),
    .push_pred_taken_i    (push_pred_taken_i),
    .push_pred_addr_i     (push_pred_addr_i),
    .push_is_pred_branch_i(push_is_pred_branch_i),
    .push_is_pred_jalr_i  (push_is_pred_jalr_i),
    .pop_valid_o          (pop_valid_o),
    .pop_ready_i          (pop_ready_i),
    .pop_inst_o           (pop_inst_o),
    .pop_pc_o             (pop_pc_o),
    .pop_pred_taken_o     (pop_pred_taken_o),
    .pop_pred_addr_o      (pop_pred_addr_o),
    .pop_is_pred_branch_o (pop_is_pred_branch_o),
    .pop_is_pred_jalr_o   (pop_is_pred_jalr_o),
    .count_o              (count_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc,
                       input logic [31:0] inst, input logic tk,
                       input logic [31:0] addr, input logic br,
                       input logic jr);
    push_valid_i          = v;
    push_pc_i             = pc;
    push_inst_i           = inst;
    push_pred_taken_i     = tk;
    push_pred_addr_i      = addr;
    push_is_pred_branch_i = br;
    push_is_pred_jalr_i   = jr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush_i = 1'b0;
    pop_ready_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) step();
    checks++;
    if (push_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_push_ready got=%b exp=1", push_ready_o);
    end
    checks++;
    if (pop_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_pop_valid got=%b exp=0", pop_valid_o);
    end
    checks++;
    if (count_o !== 3'd0) begin
      errors++;
      $display("FAIL reset_count got=%0d exp=0", count_o);
    end
    checks++;
    if ({pop_inst_o, pop_pc_o, pop_pred_addr_o} !== 96'h0) begin
      errors++;
      $display("FAIL reset_pop_data got=%h/%h/%h exp=0",
               pop_inst_o, pop_pc_o, pop_pred_addr_o);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    drive(1'b1, 32'h8000_0000, 32'h0000_0013, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (pop_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL single_no_bypass got=%b exp=0", pop_valid_o);
    end
    step();
    push_valid_i = 1'b0;
    checks++;
    if (pop_valid_o !== 1'b1 || pop_pc_o !== 32'h8000_0000 ||
        pop_inst_o !== 32'h0000_0013) begin
      errors++;
      $display("FAIL single_pop got=%b/%h/%h exp=1/80000000/00000013",
               pop_valid_o, pop_pc_o, pop_inst_o);
    end
    checks++;
    if (count_o !== 3'd1) begin
      errors++;
      $display("FAIL single_count got=%0d exp=1", count_o);
    end
    pop_ready_i = 1'b1;
    step();
    pop_ready_i = 1'b0;
    checks++;
    if (count_o !== 3'd0 || pop_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL single_drain got=%0d/%b exp=0/0", count_o, pop_valid_o);
    end
  endtask

  task automatic test_fill_and_full_pop();
    logic [31:0] exp_pc [4];
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h1000 + 32'(4 * i), 32'h100 + 32'(i),
            1'b0, 32'h0, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'h2000, 32'h200, 1'b1, 32'h2100, 1'b1, 1'b0);
    checks++;
    if (push_ready_o !== 1'b0 || count_o !== 3'd4) begin
      errors++;
      $display("FAIL full_state got=%b/%0d exp=0/4", push_ready_o, count_o);
    end
    step();
    checks++;
    if (count_o !== 3'd4 || pop_pc_o !== 32'h1000) begin
      errors++;
      $display("FAIL full_reject got=%0d/%h exp=4/00001000",
               count_o, pop_pc_o);
    end
    pop_ready_i = 1'b1;
    step();
    pop_ready_i = 1'b0;
    checks++;
    if (count_o !== 3'd3 || pop_pc_o !== 32'h1004 || push_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL full_pop_only got=%0d/%h/%b exp=3/00001004/1",
               count_o, pop_pc_o, push_ready_o);
    end
    step();
    push_valid_i = 1'b0;
    checks++;
    if (count_o !== 3'd4) begin
      errors++;
      $display("FAIL full_refill got=%0d exp=4", count_o);
    end
    exp_pc = '{32'h1004, 32'h1008, 32'h100C, 32'h2000};
    pop_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pop_valid_o !== 1'b1 || pop_pc_o !== exp_pc[i]) begin
        errors++;
        $display("FAIL drain_order[%0d] got=%b/%h exp=1/%h",
                 i, pop_valid_o, pop_pc_o, exp_pc[i]);
      end
      step();
    end
    pop_ready_i = 1'b0;
    checks++;
    if (count_o !== 3'd0) begin
      errors++;
      $display("FAIL drain_count got=%0d exp=0", count_o);
    end
  endtask

  task automatic test_stream();
    logic [31:0] epc;
    pop_ready_i = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      if (i < 10)
        drive(1'b1, 32'h8000_0000 + 32'(4 * i), 32'hA000 + 32'(i),
              i[0], 32'h9000_0000 + 32'(i), i[1], 1'b0);
      else
        push_valid_i = 1'b0;
      if (i > 0) begin
        epc = 32'h8000_0000 + 32'(4 * (i - 1));
        checks++;
        if (pop_valid_o !== 1'b1 || pop_pc_o !== epc ||
            pop_inst_o !== 32'hA000 + 32'(i - 1) ||
            pop_pred_taken_o !== (i - 1) % 2 ||
            pop_is_pred_branch_o !== ((i - 1) / 2) % 2 ||
            pop_pred_addr_o !== 32'h9000_0000 + 32'(i - 1)) begin
          errors++;
          $display("FAIL stream[%0d] got=%b/%h/%h/%b/%b exp pc=%h",
                   i - 1, pop_valid_o, pop_pc_o, pop_inst_o,
                   pop_pred_taken_o, pop_is_pred_branch_o, epc);
        end
      end
      step();
    end
    pop_ready_i = 1'b0;
    checks++;
    if (count_o !== 3'd0 || pop_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL stream_end got=%0d/%b exp=0/0", count_o, pop_valid_o);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h3000 + 32'(4 * i), 32'h300, 1'b0, 32'h0, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'h4000, 32'h400, 1'b0, 32'h0, 1'b0, 1'b0);
    flush_i = 1'b1;
    pop_ready_i = 1'b1;
    step();
    flush_i = 1'b0;
    push_valid_i = 1'b0;
    pop_ready_i = 1'b0;
    checks++;
    if (count_o !== 3'd0 || pop_valid_o !== 1'b0 || push_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_empty got=%0d/%b/%b exp=0/0/1",
               count_o, pop_valid_o, push_ready_o);
    end
    step();
    checks++;
    if (count_o !== 3'd0) begin
      errors++;
      $display("FAIL flush_push_void got=%0d exp=0", count_o);
    end
    drive(1'b1, 32'h5000, 32'h500, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    push_valid_i = 1'b0;
    checks++;
    if (pop_valid_o !== 1'b1 || pop_pc_o !== 32'h5000 || count_o !== 3'd1) begin
      errors++;
      $display("FAIL flush_next_first got=%b/%h/%0d exp=1/00005000/1",
               pop_valid_o, pop_pc_o, count_o);
    end
    flush_i = 1'b1;
    push_valid_i = 1'b1;
    repeat (2) step();
    checks++;
    if (count_o !== 3'd0 || pop_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_held got=%0d/%b exp=0/0", count_o, pop_valid_o);
    end
    flush_i = 1'b0;
    push_valid_i = 1'b0;
  endtask

  task automatic test_fields();
    drive(1'b1, 32'h8000_0040, 32'h0000_80E7, 1'b1,
          32'h8000_0100, 1'b0, 1'b1);
    step();
    push_valid_i = 1'b0;
    checks++;
    if (pop_inst_o !== 32'h0000_80E7 || pop_pc_o !== 32'h8000_0040 ||
        pop_pred_taken_o !== 1'b1 || pop_pred_addr_o !== 32'h8000_0100 ||
        pop_is_pred_branch_o !== 1'b0 || pop_is_pred_jalr_o !== 1'b1) begin
      errors++;
      $display("FAIL fields got=%h/%h/%b/%h/%b/%b exp=000080e7/80000040/1/80000100/0/1",
               pop_inst_o, pop_pc_o, pop_pred_taken_o, pop_pred_addr_o,
               pop_is_pred_branch_o, pop_is_pred_jalr_o);
    end
    step();
    checks++;
    if (pop_valid_o !== 1'b1 || pop_pred_addr_o !== 32'h8000_0100) begin
      errors++;
      $display("FAIL fields_stable got=%b/%h exp=1/80000100",
               pop_valid_o, pop_pred_addr_o);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h6000, 32'h600, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    push_valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (count_o !== 3'd0 || pop_valid_o !== 1'b0 || pop_pc_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid got=%0d/%b/%h exp=0/0/0",
               count_o, pop_valid_o, pop_pc_o);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_and_full_pop();
    test_stream();
    test_flush();
    test_fields();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_queue.md
Name: ifu_fetch_queue

Overview:
- Decoupling queue between static branch prediction and the decode stage.
- Each entry holds one fetched instruction, its PC, and the prediction results produced alongside it.
- Absorbs decode backpressure so the fetch side keeps streaming.
- Discards every held entry when the pipeline redirects.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- ADDR_W, 32, PC and target address width (INST_ADDR_WIDTH).
- DATA_W, 32, instruction width (INST_DATA_WIDTH).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- flush_i  input  1  pipeline redirect; drop all entries.
- push_valid_i  input  1  fetch side offers an entry.
- push_ready_o  output  1  queue can accept an entry.
- push_inst_i  input  DATA_W  instruction word.
- push_pc_i  input  ADDR_W  instruction PC.
- push_pred_taken_i  input  1  predicted taken.
- push_pred_addr_i  input  ADDR_W  predicted target.
- push_is_pred_branch_i  input  1  predicted conditional branch.
- push_is_pred_jalr_i  input  1  predicted JALR.
- pop_valid_o  output  1  head entry valid.
- pop_ready_i  input  1  decode consumes head.
- pop_inst_o  output  DATA_W  head instruction.
- pop_pc_o  output  ADDR_W  head PC.
- pop_pred_taken_o  output  1  head predicted taken.
- pop_pred_addr_o  output  ADDR_W  head predicted target.
- pop_is_pred_branch_o  output  1  head conditional-branch flag.
- pop_is_pred_jalr_o  output  1  head JALR flag.
- count_o  output  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Storage:
  - Circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, plus a count register.
  - Pointers wrap modulo DEPTH.
  - Each entry is 2*ADDR_W + DATA_W + 3 bits.
- Reset (async):
  - wr_ptr = rd_ptr = count = 0; all storage = 0.
  - Outputs: push_ready_o = 1, pop_valid_o = 0, count_o = 0, all pop data = 0.
- push_ready_o = (count != DEPTH).
  - Depends on registered state only; no combinational path from pop_ready_i.
- pop_valid_o = (count != 0).
  - Pop data is taken directly from entry[rd_ptr].
  - Pop data is don't-care while pop_valid_o = 0.
- Push handshake: push_valid_i & push_ready_o & ~flush_i.
  - Writes entry[wr_ptr]; wr_ptr increments.
- Pop handshake: pop_valid_o & pop_ready_i & ~flush_i.
  - rd_ptr increments.
- Latency and bypass:
  - An entry pushed in cycle N is first visible on the pop side in cycle N+1.
  - No same-cycle bypass, including when empty.
- Count update:
  - +1 on push only; -1 on pop only; unchanged on both or neither.
- Simultaneous push and pop:
  - When neither empty nor full, both complete and count is unchanged.
  - When full, push_ready_o = 0, so only the pop occurs; the freed slot accepts a push from the next cycle.
  - When empty, only the push occurs.
- Flush:
  - flush_i has highest priority. Any push or pop attempted in the same cycle is void and state is not advanced by it.
  - Next cycle: wr_ptr = rd_ptr = count = 0, pop_valid_o = 0, push_ready_o = 1.
  - Storage contents need not be cleared.
  - A flush held for several cycles keeps the queue empty and accepts nothing.
- Stability under backpressure: pop data and pop_valid_o stay stable while pop_valid_o = 1 and pop_ready_i = 0 (no flush).
- Ordering: strict FIFO. The PC/prediction tuple is never split or reordered across entries.
- Reset asserted mid-operation: all state returns immediately to reset values; in-flight entries are lost.
- Assertion (simulation only): count never exceeds DEPTH and never underflows.

Test Plan:
- Reset, then push 1 entry (inst=0x00000013, pc=0x80000000, taken=0) -> pop_valid_o=1 exactly 1 cycle after push; pop_pc_o=0x80000000; count_o=1.
- Push 4 entries with pop_ready_i=0 -> push_ready_o=0 after the 4th; a 5th push_valid_i is not accepted; count_o=4; head stays entry 0.
- Full queue, push_valid_i=1 and pop_ready_i=1 in the same cycle -> only the pop completes; count_o=3; next cycle push accepted, count_o=4.
- Continuous streaming of 10 entries (pc 0x80000000 step 4, pop_ready_i=1 every cycle) -> pops emerge in order with matching pred fields; pointers wrap past DEPTH without loss.
- 3 entries held, then flush_i=1 while push_valid_i=1 and pop_ready_i=1 -> next cycle count_o=0 and pop_valid_o=0; pushed entry absent; next push pops as first entry.
- Entry with pred_taken=1, pred_addr=0x80000100, is_pred_jalr=1 -> all fields reproduced on the pop side bit-exact.
